mem_copy_ctrl: RTL and testbench

- Sequencer for block memory-to-memory copies, up to 2^WIDTH-1 bytes.
- Sits directly downstream of the byte/word offset counter. It drives the counter's length and enable, consumes its offset and done flag, and issues read/write requests on the data-memory side port.
- Moves whole words while at least 4 bytes remain, then moves the tail as single bytes.

---
 rtl/mem_copy_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_copy_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_ctrl.sv
// mem_copy_ctrl: sequencer for block memory-to-memory copies of up to 2^WIDTH-1 bytes.
//
// Sits downstream of a byte/word offset counter. It drives the counter length and
// enable, reads the current offset, and issues read/write requests on the memory side
// port. Whole words are moved while at least 4 bytes remain. The tail is then moved
// one byte at a time.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start                begin a copy (sampled in IDLE only)
//   src_base, dst_base   base addresses, bits [1:0] forced to 0
//   xfer_len             byte count, latched on start
//   busy, done           busy in RD/WR, one-cycle completion pulse
//   counter_N/_en        length and advance strobe to the offset counter
//   counter_out/_done    current offset / last-access flag from the counter
//   rd_req/addr/word     read request, address, 1 = word access
//   rd_ack, rd_data      read completion and data (byte zero-extended in [7:0])
//   wr_req/addr/data/be  write request, address, data, byte enables
//   wr_ack               write completion
//
// Optional feature, macro MEM_COPY_IRQ_EN: adds irq_clr input and sticky irq output.
module mem_copy_ctrl #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [31:0]      src_base,
    input  logic [31:0]      dst_base,
    input  logic [WIDTH-1:0] xfer_len,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] counter_N,
    output logic             counter_en,
    input  logic [31:0]      counter_out,
    input  logic             counter_done,
    output logic             rd_req,
    output logic [31:0]      rd_addr,
    output logic             rd_word,
    input  logic             rd_ack,
    input  logic [31:0]      rd_data,
    output logic             wr_req,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic [3:0]       wr_be,
`ifdef MEM_COPY_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    input  logic             wr_ack
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

    state_e           state_q, state_d;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [WIDTH-1:0] len_q;
    logic [31:0]      data_q;
    logic             word_sel;

    // Word access while a full word still fits inside the transfer; 33 bits so the
    // +4 can never wrap.
    assign word_sel = (({1'b0, counter_out} + 33'd4) <= 33'(len_q));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = (xfer_len == '0) ? StFin : StRd;
            StRd:   if (rd_ack) state_d = StWr;
            StWr:   if (wr_ack) state_d = counter_done ? StFin : StRd;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Latched transfer parameters and captured read data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            data_q <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                src_q <= {src_base[31:2], 2'b00};
                dst_q <= {dst_base[31:2], 2'b00};
                len_q <= xfer_len;
            end
            if (state_q == StRd && rd_ack) begin
                data_q <= rd_data;
            end
        end
    end

    // Outputs; address/data buses are zero outside their request state so everything
    // reads 0 in reset and idle.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        counter_N  = len_q;
        counter_en = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        rd_word    = 1'b0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_be      = '0;
        unique case (state_q)
            StRd: begin
                busy    = 1'b1;
                rd_req  = 1'b1;
                rd_addr = src_q + counter_out;
                rd_word = word_sel;
            end
            StWr: begin
                busy    = 1'b1;
                wr_req  = 1'b1;
                wr_addr = dst_q + counter_out;
                if (word_sel) begin
                    wr_be   = 4'b1111;
                    wr_data = data_q;
                end else begin
                    wr_be   = 4'b0001 << wr_addr[1:0];
                    wr_data = {4{data_q[7:0]}};
                end
                // Counter advances in the ack cycle itself, not a cycle later.
                counter_en = wr_ack;
            end
            StFin: done = 1'b1;
            default: ;
        endcase
    end

`ifdef MEM_COPY_IRQ_EN
    logic irq_q;

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= done | (irq_q & ~irq_clr);
        end
    end

    // OR in done so irq rises in the same cycle as the completion pulse.
    assign irq = irq_q | done;
`endif

endmodule

// File: tb/tb_mem_copy_ctrl.sv
module tb_mem_copy_ctrl;

    localparam int W = 7;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [31:0]   src_base, dst_base;
    logic [W-1:0]  xfer_len;
    logic          busy, done;
    logic [W-1:0]  counter_N;
    logic          counter_en;
    logic [31:0]   counter_out;
    logic          counter_done;
    logic          rd_req, rd_word, rd_ack;
    logic [31:0]   rd_addr, rd_data;
    logic          wr_req, wr_ack;
    logic [31:0]   wr_addr, wr_data;
    logic [3:0]    wr_be;
`ifdef MEM_COPY_IRQ_EN
    logic          irq_clr;
    logic          irq;
`endif

    mem_copy_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .src_base(src_base), .dst_base(dst_base),
        .xfer_len(xfer_len), .busy(busy), .done(done), .counter_N(counter_N),
        .counter_en(counter_en), .counter_out(counter_out), .counter_done(counter_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_word(rd_word), .rd_ack(rd_ack),
        .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be),
`ifdef MEM_COPY_IRQ_EN
        .irq_clr(irq_clr), .irq(irq),
`endif
        .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    // External byte/word offset counter model
    logic [31:0] cnt_off;
    logic [32:0] cnt_step;
    always_comb begin
        cnt_step     = (({1'b0, cnt_off} + 33'd4) <= 33'(counter_N)) ? 33'd4 : 33'd1;
        counter_done = (({1'b0, cnt_off} + cnt_step) >= 33'(counter_N));
    end
    assign counter_out = cnt_off;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           cnt_off <= '0;
        else if (counter_en) cnt_off <= counter_done ? 32'd0 : cnt_off + cnt_step[31:0];
    end

    // Source memory: byte i holds i, except 0x44 holds 0xA5
    logic [7:0] smem [256];
    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic w);
        logic [7:0] b;
        b = a[7:0];
        if (w) return {smem[8'(b + 8'd3)], smem[8'(b + 8'd2)], smem[8'(b + 8'd1)], smem[b]};
        return {24'b0, smem[b]};
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard
    typedef struct {
        int          kind; // 0 read, 1 write, 2 done
        logic [31:0] addr;
        logic        word;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic exp_rd(input logic [31:0] a, input logic w);
        exp_t e; e.kind = 0; e.addr = a; e.word = w; e.be = '0; e.data = '0;
        sb.push_back(e);
    endtask
    task automatic exp_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_t e; e.kind = 1; e.addr = a; e.word = 1'b0; e.be = be; e.data = d;
        sb.push_back(e);
    endtask
    task automatic exp_done();
        exp_t e; e.kind = 2; e.addr = '0; e.word = 1'b0; e.be = '0; e.data = '0;
        sb.push_back(e);
    endtask

    // Memory responder with configurable wait states
    int rd_wait = 0, wr_wait = 0;
    int rd_cnt = 0, wr_cnt = 0;
    initial begin
        rd_ack = 1'b0; wr_ack = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk); #1;
            rd_ack = 1'b0; wr_ack = 1'b0;
            if (rd_req) begin
                if (rd_cnt >= rd_wait) begin
                    rd_ack = 1'b1; rd_data = mem_read(rd_addr, rd_word); rd_cnt = 0;
                end else rd_cnt++;
            end else rd_cnt = 0;
            if (wr_req) begin
                if (wr_cnt >= wr_wait) begin
                    wr_ack = 1'b1; wr_cnt = 0;
                end else wr_cnt++;
            end else wr_cnt = 0;
        end
    end

    // Monitor
    int rd_cyc, wr_cyc, en_cyc, busy_cyc, done_cyc;
    logic        p_rd_req, p_rd_ack, p_rd_word, p_wr_req, p_wr_ack;
    logic [31:0] p_rd_addr, p_off;
    initial begin
        exp_t e;
        p_rd_req = 0; p_rd_ack = 0; p_rd_word = 0; p_wr_req = 0; p_wr_ack = 0;
        p_rd_addr = '0; p_off = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                p_rd_req = 0; p_wr_req = 0;
            end else begin
                rd_cyc   += int'(rd_req);
                wr_cyc   += int'(wr_req);
                en_cyc   += int'(counter_en);
                busy_cyc += int'(busy);
                done_cyc += int'(done);
                check("counter_en_vs_ack", {31'b0, counter_en}, {31'b0, wr_req & wr_ack});
                check("busy_vs_req", {31'b0, busy}, {31'b0, rd_req | wr_req});
                if (rd_req && p_rd_req && !p_rd_ack) begin
                    check("rd_addr_stable", rd_addr, p_rd_addr);
                    check("rd_word_stable", {31'b0, rd_word}, {31'b0, p_rd_word});
                end
                if (wr_req && p_wr_req && !p_wr_ack)
                    check("offset_stable_in_wr", counter_out, p_off);
                if ((rd_req && rd_ack) || (wr_req && wr_ack) || done) begin
                    if (sb.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_event: got rd=%b wr=%b done=%b expected none",
                                 rd_req & rd_ack, wr_req & wr_ack, done);
                    end else begin
                        e = sb.pop_front();
                        if (rd_req && rd_ack) begin
                            check("rd_kind", 32'd0, e.kind);
                            check("rd_addr", rd_addr, e.addr);
                            check("rd_word", {31'b0, rd_word}, {31'b0, e.word});
                        end else if (wr_req && wr_ack) begin
                            check("wr_kind", 32'd1, e.kind);
                            check("wr_addr", wr_addr, e.addr);
                            check("wr_be", {28'b0, wr_be}, {28'b0, e.be});
                            check("wr_data", wr_data, e.data);
                        end else begin
                            check("done_kind", 32'd2, e.kind);
                        end
                    end
                end
                p_rd_req = rd_req; p_rd_ack = rd_ack; p_rd_word = rd_word;
                p_rd_addr = rd_addr; p_wr_req = wr_req; p_wr_ack = wr_ack; p_off = counter_out;
            end
        end
    end

    task automatic clr_counts();
        rd_cyc = 0; wr_cyc = 0; en_cyc = 0; busy_cyc = 0; done_cyc = 0;
    endtask

    task automatic start_copy(input int len, input logic [31:0] s, input logic [31:0] d);
        @(posedge clk); #1;
        start = 1'b1; xfer_len = W'(len); src_base = s; dst_base = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) smem[i] = 8'(i);
        smem[8'h44] = 8'hA5;
        start = 0; src_base = '0; dst_base = '0; xfer_len = '0;
`ifdef MEM_COPY_IRQ_EN
        irq_clr = 0;
`endif
        rstn = 0;
        clr_counts();
        #23;
        // Reset state
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rd_req", {31'b0, rd_req}, 32'd0);
        check("rst_wr_req", {31'b0, wr_req}, 32'd0);
        check("rst_counter_N", {25'b0, counter_N}, 32'd0);
        check("rst_wr_be", {28'b0, wr_be}, 32'd0);
        check("rst_rd_addr", rd_addr, 32'd0);
`ifdef MEM_COPY_IRQ_EN
        check("rst_irq", {31'b0, irq}, 32'd0);
`endif
        @(negedge clk); rstn = 1;

        // Stray acks in IDLE are ignored
        @(posedge clk); #2;
        rd_ack = 1'b1; wr_ack = 1'b1;
        @(negedge clk);
        check("stray_ack_busy", {31'b0, busy}, 32'd0);
        check("stray_ack_en", {31'b0, counter_en}, 32'd0);
        @(negedge clk);
        check("stray_ack_busy2", {31'b0, busy}, 32'd0);
        check("stray_ack_done", {31'b0, done}, 32'd0);

        // len=8 word copy
        clr_counts();
        exp_rd(32'h100, 1); exp_wr(32'h200, 4'b1111, 32'h03020100);
        exp_rd(32'h104, 1); exp_wr(32'h204, 4'b1111, 32'h07060504);
        exp_done();
        start_copy(8, 32'h100, 32'h200);
        wait_done();
        check("len8_en_count", en_cyc, 2);
        check("len8_offset_wrap", counter_out, 32'd0);
        check("len8_sb_empty", sb.size(), 0);

        // len=6: word then two bytes
        clr_counts();
        exp_rd(32'h40, 1); exp_wr(32'h80, 4'b1111, 32'h43424140);
        exp_rd(32'h44, 0); exp_wr(32'h84, 4'b0001, 32'hA5A5A5A5);
        exp_rd(32'h45, 0); exp_wr(32'h85, 4'b0010, 32'h45454545);
        exp_done();
        start_copy(6, 32'h40, 32'h80);
        wait_done();
        check("len6_en_count", en_cyc, 3);
        check("len6_sb_empty", sb.size(), 0);

        // len=0: no traffic
        clr_counts();
        exp_done();
        start_copy(0, 32'h100, 32'h200);
        wait_done();
        repeat (3) @(posedge clk);
        check("len0_rd", rd_cyc, 0);
        check("len0_wr", wr_cyc, 0);
        check("len0_en", en_cyc, 0);
        check("len0_busy", busy_cyc, 0);
        check("len0_done_cycles", done_cyc, 1);
        check("len0_sb_empty", sb.size(), 0);

        // Wait states: 3 on read, 2 on write, len=5
        clr_counts();
        rd_wait = 3; wr_wait = 2;
        exp_rd(32'h10, 1); exp_wr(32'h20, 4'b1111, 32'h13121110);
        exp_rd(32'h14, 0); exp_wr(32'h24, 4'b0001, 32'h14141414);
        exp_done();
        start_copy(5, 32'h10, 32'h20);
        wait_done();
        rd_wait = 0; wr_wait = 0;
        check("wait_rd_cycles", rd_cyc, 8);
        check("wait_wr_cycles", wr_cyc, 6);
        check("wait_en_count", en_cyc, 2);
        check("wait_sb_empty", sb.size(), 0);

        // start while busy is ignored (len=3 in flight)
        exp_rd(32'h08, 0); exp_wr(32'h30, 4'b0001, 32'h08080808);
        exp_rd(32'h09, 0); exp_wr(32'h31, 4'b0010, 32'h09090909);
        exp_rd(32'h0A, 0); exp_wr(32'h32, 4'b0100, 32'h0A0A0A0A);
        exp_done();
        start_copy(3, 32'h08, 32'h30);
        @(posedge clk); #1;
        start = 1'b1; xfer_len = W'(9); src_base = 32'h999; dst_base = 32'h777;
        @(negedge clk);
        check("busy_start_N", {25'b0, counter_N}, 32'd3);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_start_N2", {25'b0, counter_N}, 32'd3);
        wait_done();
        check("busy_start_sb_empty", sb.size(), 0);

        // Reset during WR aborts with no done
        wr_wait = 20;
        exp_rd(32'h100, 1);
        start_copy(8, 32'h100, 32'h200);
        begin
            bit seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (wr_req) begin seen = 1; break; end
            end
            check("abort_reached_wr", {31'b0, seen}, 32'd1);
        end
        #2 rstn = 0;
        #1;
        check("abort_wr_req", {31'b0, wr_req}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_rd_req", {31'b0, rd_req}, 32'd0);
        check("abort_sb_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rstn = 1;
        wr_wait = 0;
        repeat (3) @(posedge clk);

        // New len=4 copy after abort starts at offset 0
        check("post_abort_offset", counter_out, 32'd0);
        exp_rd(32'h60, 1); exp_wr(32'h70, 4'b1111, 32'h63626160);
        exp_done();
        start_copy(4, 32'h60, 32'h70);
        wait_done();
        check("post_abort_sb_empty", sb.size(), 0);
        check("post_abort_offset_end", counter_out, 32'd0);

`ifdef MEM_COPY_IRQ_EN
        // len=1 copy: irq rises with done and holds until cleared
        exp_rd(32'h04, 0); exp_wr(32'h50, 4'b0001, 32'h04040404);
        exp_done();
        start_copy(1, 32'h06, 32'h53);
        begin
            bit seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (done) begin seen = 1; break; end
            end
            check("irq_done_seen", {31'b0, seen}, 32'd1);
            check("irq_with_done", {31'b0, irq}, 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("irq_held", {31'b0, irq}, 32'd1);
        end
        @(posedge clk); #1 irq_clr = 1;
        @(posedge clk); #1 irq_clr = 0;
        @(negedge clk);
        check("irq_cleared", {31'b0, irq}, 32'd0);
        // Clear coinciding with done: set wins
        exp_done();
        start_copy(0, 32'h0, 32'h0);
        irq_clr = 1;
        @(negedge clk);
        check("irq_coinc_done", {31'b0, done}, 32'd1);
        @(posedge clk); #1 irq_clr = 0;
        @(negedge clk);
        check("irq_set_wins", {31'b0, irq}, 32'd1);
        check("irq_sb_empty", sb.size(), 0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
